stereo_sad_disparity: RTL and testbench

- Streaming, parametrised block-matching disparity core for the stereo depth-map pipeline.
- Sits between the rectified left/right frame-buffer readers and the disparity RAM write port.
- Accepts one rectified left/right pixel pair per valid cycle and computes a horizontal-window SAD cost for each candidate disparity.
- Emits the winning disparity, a confidence flag and the matching disparity-RAM write address.
- Generalises the fixed 4-bit, fixed-range generator to configurable pixel width, disparity range and window size, and adds bubble tolerance and confidence output.

---
 rtl/stereo_sad_disparity.sv | 140 ++++++++++++++
 tb/tb_stereo_sad_disparity.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_sad_disparity.sv
`default_nettype none
// ============================================================================
// Module      : stereo_sad_disparity
// Description : Streaming horizontal-window SAD block matcher. Emits the
//               winning disparity, a confidence flag and the RAM write address.
//               Optional macro STEREO_SAD_COST_THRESH_EN gates conf_out on the
//               winning cost being <= COST_THRESH.
// Revision    : 1.0 - initial release
// ============================================================================
module stereo_sad_disparity #(
    parameter int PIX_W       = 4,
    parameter int MAX_DISP    = 16,
    parameter int WIN         = 5,
    parameter int ADDR_W      = 17,
    parameter int COST_THRESH = 40
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic                        line_start,
    input  logic                        frame_start,
    input  logic [PIX_W-1:0]            left_in,
    input  logic [PIX_W-1:0]            right_in,
    output logic                        out_valid,
    output logic [$clog2(MAX_DISP)-1:0] disp_out,
    output logic                        conf_out,
    output logic [ADDR_W-1:0]           out_addr
);

    localparam int c_disp_w = $clog2(MAX_DISP);
    localparam int c_cost_w = PIX_W + $clog2(WIN) + 1;
    // Only needs to reach the largest eligibility threshold before saturating.
    localparam int c_col_w  = $clog2(MAX_DISP + WIN);

    logic [c_col_w-1:0]  r_col;
    logic [c_col_w-1:0]  w_col;
    logic [PIX_W-1:0]    r_rsh [MAX_DISP-1];
    logic [MAX_DISP-1:0] w_elig;
    logic [MAX_DISP-1:0] r_s1_elig;
    logic                r_s1_valid;
    logic                r_s1_frame;
    logic [c_cost_w-1:0] w_cost [MAX_DISP];
    logic [c_cost_w-1:0] w_best_cost;
    logic [c_disp_w-1:0] w_best_d;
    logic                w_conf;
    logic [ADDR_W-1:0]   r_addr;

    assign w_col = line_start ? '0 : r_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_DISP - 1; i++) r_rsh[i] <= '0;
        end else if (in_valid) begin
            r_rsh[0] <= right_in;
            for (int i = 1; i < MAX_DISP - 1; i++) r_rsh[i] <= r_rsh[i-1];
        end
    end

    generate
        for (genvar d = 0; d < MAX_DISP; d++) begin : g_disp
            localparam logic [c_col_w-1:0] c_min_col = c_col_w'(d + WIN - 1);

            logic [PIX_W-1:0]    w_rpix;
            logic [PIX_W-1:0]    w_diff;
            logic [PIX_W-1:0]    r_ring [WIN];
            logic [c_cost_w-1:0] r_sum;

            if (d == 0) begin : g_d0
                assign w_rpix = right_in;
            end else begin : g_dn
                assign w_rpix = r_rsh[d-1];
            end

            assign w_diff    = (left_in > w_rpix) ? left_in - w_rpix : w_rpix - left_in;
            assign w_elig[d] = (w_col >= c_min_col);
            assign w_cost[d] = r_s1_elig[d] ? r_sum : '1;

            // A line start discards the previous line's window contents.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < WIN; k++) r_ring[k] <= '0;
                    r_sum <= '0;
                end else if (in_valid) begin
                    r_ring[0] <= w_diff;
                    for (int k = 1; k < WIN; k++) r_ring[k] <= line_start ? '0 : r_ring[k-1];
                    r_sum <= line_start ? c_cost_w'(w_diff)
                                        : r_sum + c_cost_w'(w_diff) - c_cost_w'(r_ring[WIN-1]);
                end
            end
        end
    endgenerate

    // Strict less-than keeps the smallest d on ties and d=0 when nothing is eligible.
    always_comb begin
        w_best_cost = '1;
        w_best_d    = '0;
        for (int i = 0; i < MAX_DISP; i++) begin
            if (w_cost[i] < w_best_cost) begin
                w_best_cost = w_cost[i];
                w_best_d    = c_disp_w'(i);
            end
        end
    end

`ifdef STEREO_SAD_COST_THRESH_EN
    assign w_conf = r_s1_elig[0] && (int'(w_best_cost) <= COST_THRESH);
`else
    assign w_conf = r_s1_elig[0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_frame <= 1'b0;
            r_s1_elig  <= '0;
            r_addr     <= '0;
            out_valid  <= 1'b0;
            disp_out   <= '0;
            conf_out   <= 1'b0;
            out_addr   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_frame <= in_valid & frame_start;
            out_valid  <= r_s1_valid;
            if (in_valid) begin
                r_s1_elig <= w_elig;
                r_col     <= (&w_col) ? w_col : w_col + c_col_w'(1);
            end
            if (r_s1_valid) begin
                disp_out <= w_best_d;
                conf_out <= w_conf;
                out_addr <= r_s1_frame ? '0 : r_addr;
                r_addr   <= (r_s1_frame ? '0 : r_addr) + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stereo_sad_disparity.sv
`default_nettype none
// ============================================================================
// Module      : tb_stereo_sad_disparity
// Description : Directed self-checking bench for stereo_sad_disparity (default
//               build plus a 4-bit address instance for wrap behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stereo_sad_disparity;

    localparam int PIX_W    = 4;
    localparam int MAX_DISP = 16;
    localparam int WIN      = 5;
    localparam int ADDR_W   = 17;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              line_start = 1'b0;
    logic              frame_start = 1'b0;
    logic [PIX_W-1:0]  left_in = '0;
    logic [PIX_W-1:0]  right_in = '0;
    logic              out_valid;
    logic [3:0]        disp_out;
    logic              conf_out;
    logic [ADDR_W-1:0] out_addr;
    logic              w4_valid;
    logic [3:0]        w4_disp;
    logic              w4_conf;
    logic [3:0]        w4_addr;

    always #5 clk = ~clk;

    stereo_sad_disparity u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .line_start(line_start),
        .frame_start(frame_start), .left_in(left_in), .right_in(right_in),
        .out_valid(out_valid), .disp_out(disp_out), .conf_out(conf_out), .out_addr(out_addr)
    );

    stereo_sad_disparity #(.ADDR_W(4)) u_dut_w4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .line_start(line_start),
        .frame_start(frame_start), .left_in(left_in), .right_in(right_in),
        .out_valid(w4_valid), .disp_out(w4_disp), .conf_out(w4_conf), .out_addr(w4_addr)
    );

    typedef struct {
        int disp;
        int conf;
        int addr;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    int   lh[128];
    int   rh[128];
    int   m_col_next = 0;
    int   m_addr_next = 0;
    bit   mon_en = 1'b0;
    logic [1:0] vh;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lpat(input int x);
        return (7 * x + 3 * (x / 4)) % 16;
    endfunction

    // Reference: full window recomputation for every eligible disparity.
    function automatic void model(input int c, output int bd, output int cf);
        int best;
        int s;
        int t;
        best = 1 << 30;
        bd   = 0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (c >= d + WIN - 1) begin
                s = 0;
                for (int k = 0; k < WIN; k++) begin
                    t = lh[c-k] - rh[c-k-d];
                    s += (t < 0) ? -t : t;
                end
                if (s < best) begin
                    best = s;
                    bd   = d;
                end
            end
        end
        cf = (c >= WIN - 1) ? 1 : 0;
`ifdef STEREO_SAD_COST_THRESH_EN
        if (best > 40) cf = 0;
`endif
    endfunction

    task automatic drive_px(input bit v, input bit ls, input bit fs,
                            input int lp, input int rp, input bit hand);
        int   c;
        int   bd;
        int   cf;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = v;
        line_start  = ls;
        frame_start = fs;
        left_in     = 4'(lp);
        right_in    = 4'(rp);
        if (v) begin
            c = ls ? 0 : m_col_next;
            m_col_next = c + 1;
            lh[c] = lp;
            rh[c] = rp;
            if (hand) begin
                bd = 0;
                cf = (c >= WIN - 1) ? 1 : 0;
            end else begin
                model(c, bd, cf);
            end
            e.disp = bd;
            e.conf = cf;
            e.addr = fs ? 0 : m_addr_next;
            m_addr_next = (e.addr + 1) % (1 << ADDR_W);
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) vh <= 2'b00;
        else          vh <= {vh[0], in_valid};
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check_value("out_valid_lat", {31'd0, out_valid}, {31'd0, vh[1]});
            check_value("w4_valid_lat", {31'd0, w4_valid}, {31'd0, vh[1]});
            if (out_valid) begin
                check_value("pending_exp", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_value("disp_out", disp_out, e.disp);
                    check_value("conf_out", conf_out, e.conf);
                    check_value("out_addr", out_addr, e.addr);
                    check_value("w4_disp", w4_disp, e.disp);
                    check_value("w4_conf", w4_conf, e.conf);
                    check_value("w4_addr", w4_addr, e.addr % 16);
                end
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_disp_out", disp_out, 0);
        check_value("rst_conf_out", conf_out, 0);
        check_value("rst_out_addr", out_addr, 0);
        check_value("rst_w4_addr", w4_addr, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Right = left shifted by 3, continuous; w4 instance wraps 0..15
        for (int c = 0; c < 64; c++)
            drive_px(1'b1, c == 0, c == 0, lpat(c), lpat(c + 3), 1'b0);

        // New frame while the previous line's last outputs are still pending
        for (int c = 0; c < 64; c++)
            drive_px(1'b1, c == 0, c == 0, 9, 9, 1'b1);

        // Bubble pattern 1,0,0,1; bubble cycles carry ignored line/frame starts
        begin
            int c;
            int p;
            c = 0;
            p = 0;
            while (c < 64) begin
                if ((p % 4 == 0) || (p % 4 == 3)) begin
                    drive_px(1'b1, c == 0, 1'b0, lpat(c), lpat(c + 3), 1'b0);
                    c++;
                end else begin
                    drive_px(1'b0, 1'b1, 1'b1, 15, 0, 1'b0);
                end
                p++;
            end
        end

        // Mid-line reset at column 20
        for (int c = 0; c < 20; c++)
            drive_px(1'b1, c == 0, c == 0, lpat(c), lpat(c + 3), 1'b0);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        mon_en      = 1'b0;
        reset_n     = 1'b0;
        q.delete();
        m_col_next  = 0;
        m_addr_next = 0;
        #3;
        check_value("midrst_out_valid", out_valid, 0);
        check_value("midrst_disp_out", disp_out, 0);
        check_value("midrst_conf_out", conf_out, 0);
        check_value("midrst_out_addr", out_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Restart without line/frame start: reset alone must give col 0, address 0
        for (int c = 0; c < 12; c++)
            drive_px(1'b1, 1'b0, 1'b0, lpat(c), lpat(c + 3), 1'b0);

        repeat (4) drive_px(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_value("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
